spi_regfile: RTL and testbench



---
 rtl/spi_regfile.sv | 158 +++++++++++++++
 tb/tb_spi_regfile.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/spi_regfile.sv
// SPI mode-0 peripheral decoding write frames into NUM_REGS x DATA_W config registers.
// Define SPI_READBACK_EN to build the register readback shifter on cipo.
module spi_regfile #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 7,
  parameter int NUM_REGS = 5,
  parameter logic [NUM_REGS*DATA_W-1:0] RESET_VAL = '0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         sclk,
  input  logic                         ncs,
  input  logic                         copi,
  output logic                         cipo,
  output logic                         cipo_oe,
  output logic [NUM_REGS*DATA_W-1:0]   regs_out,
  output logic [NUM_REGS-1:0]          wr_strobe,
  output logic                         frame_err
);
  localparam int FRAME_LEN = 1 + ADDR_W + DATA_W;
  localparam int CNT_W     = $clog2(FRAME_LEN + 2);
  localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(FRAME_LEN);
  localparam logic [CNT_W-1:0]  CNT_OVR  = CNT_W'(FRAME_LEN + 1);
  localparam logic [ADDR_W:0]   NREGS_A  = (ADDR_W+1)'(NUM_REGS);

  typedef enum logic [1:0] {IDLE, SHIFT, OVERRUN} state_t;

  // [0]/[1] synchroniser, [2] history for edge detection
  logic [2:0] sclk_q, ncs_q, copi_q;
  logic       sclk_rise, ncs_rise, ncs_fall;

  state_t                              state_q;
  logic [CNT_W-1:0]                    cnt_q;
  logic [FRAME_LEN-1:0]                sr_q;
  logic                                skip_q;
  logic [1:0]                          flush_q;
  logic [NUM_REGS-1:0][DATA_W-1:0]     regs_q;
  logic [NUM_REGS-1:0]                 strobe_q, strobe_d;
  logic                                err_q, err_d;
  logic                                commit;
  logic                                frm_rw;
  logic [ADDR_W-1:0]                   frm_addr;
  logic [DATA_W-1:0]                   frm_data;

  assign sclk_rise = sclk_q[1] & ~sclk_q[2];
  assign ncs_rise  = ncs_q[1]  & ~ncs_q[2];
  assign ncs_fall  = ~ncs_q[1] &  ncs_q[2];

  assign frm_rw   = sr_q[FRAME_LEN-1];
  assign frm_addr = sr_q[DATA_W +: ADDR_W];
  assign frm_data = sr_q[DATA_W-1:0];
  assign commit   = ncs_rise && !skip_q && (state_q != IDLE);

  always_comb begin
    strobe_d = '0;
    err_d    = 1'b0;
    if (commit) begin
      if (cnt_q != CNT_FULL)
        err_d = 1'b1;
      else if (frm_rw && ({1'b0, frm_addr} < NREGS_A))
        for (int i = 0; i < NUM_REGS; i++)
          strobe_d[i] = (frm_addr == ADDR_W'(i));
    end
  end

  // skip_q swallows a frame interrupted by reset: the synchroniser reloads ncs=1,
  // so a still-low pin looks like a fresh fall that must not start a frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_q   <= 3'b000;
      ncs_q    <= 3'b111;
      copi_q   <= 3'b000;
      state_q  <= IDLE;
      cnt_q    <= '0;
      sr_q     <= '0;
      skip_q   <= 1'b1;
      flush_q  <= 2'b11;
      regs_q   <= RESET_VAL;
      strobe_q <= '0;
      err_q    <= 1'b0;
    end else begin
      sclk_q   <= {sclk_q[1:0], sclk};
      ncs_q    <= {ncs_q[1:0],  ncs};
      copi_q   <= {copi_q[1:0], copi};
      flush_q  <= {flush_q[0], 1'b0};
      strobe_q <= strobe_d;
      err_q    <= err_d;
      for (int i = 0; i < NUM_REGS; i++)
        if (strobe_d[i]) regs_q[i] <= frm_data;

      if (ncs_rise) begin
        state_q <= IDLE;
        skip_q  <= 1'b0;
      end else if (skip_q) begin
        if (flush_q == 2'b00 && ncs_q[1] && ncs_q[2]) skip_q <= 1'b0;
      end else begin
        case (state_q)
          IDLE: if (ncs_fall) begin
            state_q <= SHIFT;
            cnt_q   <= '0;
          end
          SHIFT: if (sclk_rise) begin
            if (cnt_q == CNT_FULL) begin
              state_q <= OVERRUN;
              cnt_q   <= CNT_OVR;
            end else begin
              // history copy of copi settled at least a cycle before the edge
              sr_q  <= {sr_q[FRAME_LEN-2:0], copi_q[2]};
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign regs_out  = regs_q;
  assign wr_strobe = strobe_q;
  assign frame_err = err_q;

`ifdef SPI_READBACK_EN
  localparam logic [CNT_W-1:0] CNT_HDR = CNT_W'(1 + ADDR_W);

  logic              sclk_fall;
  logic [DATA_W-1:0] osr_q, rd_val;
  logic [ADDR_W-1:0] hdr_addr;

  assign sclk_fall = ~sclk_q[1] & sclk_q[2];
  assign hdr_addr  = sr_q[ADDR_W-1:0];

  always_comb begin
    rd_val = '0;
    for (int i = 0; i < NUM_REGS; i++)
      if (hdr_addr == ADDR_W'(i)) rd_val = regs_q[i];
  end

  // Load on the falling edge after the header so the MSB is ready for the first data rise;
  // shifting zeros in leaves cipo low once the data field is exhausted.
  always_ff @(posedge clk) begin
    if (rst || ncs_rise) begin
      osr_q <= '0;
    end else if (sclk_fall && !skip_q && state_q == SHIFT) begin
      if (cnt_q == CNT_HDR)
        osr_q <= sr_q[ADDR_W] ? '0 : rd_val;
      else if (cnt_q > CNT_HDR)
        osr_q <= {osr_q[DATA_W-2:0], 1'b0};
    end
  end

  assign cipo    = osr_q[DATA_W-1];
  assign cipo_oe = ~ncs_q[1];
`else
  assign cipo    = 1'b0;
  assign cipo_oe = 1'b0;
`endif

endmodule

// File: tb/tb_spi_regfile.sv
// Randomised frame-level bench for spi_regfile against a register-array reference model.
module tb_spi_regfile;
  localparam int DATA_W   = 8;
  localparam int ADDR_W   = 7;
  localparam int NUM_REGS = 5;
  localparam int FL       = 1 + ADDR_W + DATA_W;

  logic clk = 1'b0, rst = 1'b1, sclk = 1'b0, ncs = 1'b1, copi = 1'b0;
  logic cipo, cipo_oe, frame_err;
  logic [NUM_REGS*DATA_W-1:0] regs_out;
  logic [NUM_REGS-1:0]        wr_strobe;

  int n_chk = 0, n_fail = 0;
  logic [DATA_W-1:0] mdl [NUM_REGS];

  spi_regfile #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_REGS(NUM_REGS)) dut (
    .clk(clk), .rst(rst), .sclk(sclk), .ncs(ncs), .copi(copi),
    .cipo(cipo), .cipo_oe(cipo_oe), .regs_out(regs_out),
    .wr_strobe(wr_strobe), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [NUM_REGS*DATA_W-1:0] mdl_flat();
    logic [NUM_REGS*DATA_W-1:0] f;
    for (int i = 0; i < NUM_REGS; i++) f[i*DATA_W +: DATA_W] = mdl[i];
    return f;
  endfunction

  // Sends the low n bits of w MSB-first, optionally pulsing rst before bit rst_at,
  // then raises ncs and checks strobe/err timing, register image and cipo traces.
  task automatic run_frame(input logic [31:0] w, input int n, input int rst_at, input string tag);
    logic [31:0] ctr, otr, exp_ctr, exp_otr;
    logic [29:0] stb_tr, exp_stb_tr;
    logic [5:0]  err_tr, exp_err_tr;
    logic [NUM_REGS*DATA_W-1:0] r_pre, r_post, exp_pre;
    logic oe_idle, rw, exp_err;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] rdv;
    logic [NUM_REGS-1:0] exp_stb;

    ctr = '0; otr = '0; exp_ctr = '0; exp_otr = '0; exp_stb = '0; exp_err = 1'b0;
    stb_tr = '0; err_tr = '0; r_pre = '0; r_post = '0; oe_idle = 1'b0; rdv = '0;
    rw = (n > 0) ? w[n-1] : 1'b0;
    addr = '0;
    for (int j = 1; j <= ADDR_W && j < n; j++) addr = {addr[ADDR_W-2:0], w[n-1-j]};

`ifdef SPI_READBACK_EN
    for (int k = 0; k < n && k < 32; k++) exp_otr[k] = 1'b1;
    if (n > 1 + ADDR_W && !rw) begin
      rdv = (int'(addr) < NUM_REGS) ? mdl[addr] : '0;
      for (int k = 1 + ADDR_W; k < n && k < FL; k++) exp_ctr[k] = rdv[FL-1-k];
    end
`endif

    if (rst_at >= 0) begin
      for (int i = 0; i < NUM_REGS; i++) mdl[i] = '0;
    end
    exp_pre = mdl_flat();
    if (rst_at < 0) begin
      if (n != FL) exp_err = 1'b1;
      else if (rw && int'(addr) < NUM_REGS) begin
        exp_stb[addr] = 1'b1;
        mdl[addr] = w[DATA_W-1:0];
      end
    end
    exp_stb_tr = 30'(exp_stb) << 10;
    exp_err_tr = 6'(exp_err) << 2;

    @(negedge clk); ncs = 1'b0; clks(4);
    for (int k = 0; k < n; k++) begin
      if (k == rst_at) begin rst = 1'b1; clks(1); rst = 1'b0; end
      copi = w[n-1-k]; clks(4);
      ctr[k] = cipo; otr[k] = cipo_oe;
      sclk = 1'b1; clks(4); sclk = 1'b0;
    end
    copi = 1'b0; clks(4);

    ncs = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      stb_tr[(c-1)*NUM_REGS +: NUM_REGS] = wr_strobe;
      err_tr[c-1] = frame_err;
      if (c == 2) r_pre = regs_out;
      if (c == 6) begin r_post = regs_out; oe_idle = cipo_oe; end
    end
    clks(2);

    if (rst_at < 0) begin
      chk({tag, "/cipo"}, 64'(ctr), 64'(exp_ctr));
      chk({tag, "/cipo_oe"}, 64'(otr), 64'(exp_otr));
    end
    chk({tag, "/strobe_trace"}, 64'(stb_tr), 64'(exp_stb_tr));
    chk({tag, "/err_trace"}, 64'(err_tr), 64'(exp_err_tr));
    chk({tag, "/regs_before"}, 64'(r_pre), 64'(exp_pre));
    chk({tag, "/regs_after"}, 64'(r_post), 64'(mdl_flat()));
    chk({tag, "/oe_idle"}, 64'(oe_idle), 64'd0);
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] base;
    logic [31:0] w;
    logic        rw;
    logic [ADDR_W-1:0] a;
    int n, sel;

    for (int i = 0; i < NUM_REGS; i++) mdl[i] = '0;
    rst = 1'b1; clks(4); rst = 1'b0; clks(5);
    chk("rst/regs_out", 64'(regs_out), 64'd0);
    chk("rst/wr_strobe", 64'(wr_strobe), 64'd0);
    chk("rst/frame_err", 64'(frame_err), 64'd0);
    chk("rst/cipo", 64'(cipo), 64'd0);
    chk("rst/cipo_oe", 64'(cipo_oe), 64'd0);

    run_frame({16'h0, 1'b1, 7'h02, 8'hA5}, 16, -1, "wr_a2_a5");
    run_frame({16'h0, 1'b1, 7'h10, 8'hFF}, 16, -1, "wr_oor");
    base = {1'b1, 7'h01, 8'h5A};
    run_frame(32'(base) >> 1, 15, -1, "short15");
    run_frame({15'h0, base, 1'b1}, 17, -1, "long17");
    run_frame(32'h0, 0, -1, "zero_bits");
    run_frame({16'h0, 1'b1, 7'h04, 8'h3C}, 16, -1, "wr_a4_3c");
    run_frame({16'h0, 1'b0, 7'h04, 8'h00}, 16, -1, "rd_a4");
    run_frame({16'h0, 1'b0, 7'h7F, 8'h00}, 16, -1, "rd_oor");

    for (int t = 0; t < 40; t++) begin
      rw = 1'($urandom_range(0, 1));
      a  = ($urandom_range(0, 7) == 7) ? 7'($urandom) : 7'($urandom_range(0, 7));
      base = {rw, a, 8'($urandom)};
      sel = $urandom_range(0, 9);
      if (sel < 7)       n = FL;
      else if (sel == 7) n = ($urandom_range(0, 1) == 1) ? FL + 1 : FL - 1;
      else if (sel == 8) n = 0;
      else               n = $urandom_range(1, 20);
      if (n <= FL) w = 32'(base) >> (FL - n);
      else         w = (32'(base) << (n - FL)) | ($urandom & ((32'd1 << (n - FL)) - 32'd1));
      run_frame(w, n, -1, $sformatf("rand%0d", t));
    end

    run_frame({16'h0, 1'b1, 7'h03, 8'h77}, 16, -1, "wr_a3_77");
    run_frame({16'h0, 1'b1, 7'h04, 8'hC3}, 16, 8, "rst_mid");
    run_frame({16'h0, 1'b1, 7'h00, 8'h11}, 16, -1, "wr_after_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
